// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the floating-point multiplier back end:
// FSM state encoding, IEEE single field widths and status flag bundle.
package fp_mult_pkg;

   typedef enum logic [2:0] {
      IDLE,
      NORM,
      DENORM,
      ROUND,
      DONE
   } state_t;

   localparam int BIAS        = 127;
   localparam int EXP_MAX     = 255;
   localparam int EXP_FIELD_W = 8;
   localparam int FRAC_W      = 23;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef struct packed {
      logic exception;
      logic overflow;
      logic underflow;
      logic inexact;
   } flags_t;

   function automatic logic [31:0] pack_inf(input logic sign);
      return {sign, {EXP_FIELD_W{1'b1}}, {FRAC_W{1'b0}}};
   endfunction

endpackage

// File: rtl/fp_mult_norm_round_if.sv
// Product-in / result-out handshake bundle between the mantissa-multiply
// stage, the normalize/round stage and the consumer of the packed result.
interface fp_mult_norm_round_if #(
   parameter int EXP_W  = 10,
   parameter int MANT_W = 48
);
   logic                    in_valid;
   logic                    in_ready;
   logic                    in_sign;
   logic signed [EXP_W-1:0] in_exp;
   logic [MANT_W-1:0]       in_mant;
   logic                    in_zero;
   logic                    in_inf;
   logic                    in_nan;

   logic                    out_valid;
   logic                    out_ready;
   logic [31:0]             result;
   logic                    exception;
   logic                    overflow;
   logic                    underflow;
   logic                    inexact;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, in_zero, in_inf, in_nan,
      output out_ready,
      input  in_ready, out_valid, result, exception, overflow, underflow, inexact
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, in_zero, in_inf, in_nan,
      input  out_ready,
      output in_ready, out_valid, result, exception, overflow, underflow, inexact
   );
endinterface

// File: rtl/fp_round_pack.sv
// Combinational round-to-nearest-even, carry renormalization, IEEE single
// packing and flag generation for an already normalized significand.
module fp_round_pack
   import fp_mult_pkg::*;
#(
   parameter int EXP_W  = 10,
   parameter int MANT_W = 48
) (
   input  logic                    sign,
   input  logic signed [EXP_W-1:0] exp,
   input  logic [MANT_W-2:0]       mant,
   input  logic                    sticky,
   output logic [31:0]             result,
   output flags_t                  flags
);

   localparam int HI  = MANT_W - 2;
   localparam int LSB = HI - FRAC_W;
   localparam int GRD = LSB - 1;
   localparam logic signed [EXP_W-1:0] EXP_OVF = EXP_W'(EXP_MAX);

   logic                    guard;
   logic                    st;
   logic                    round_up;
   logic [FRAC_W+1:0]       sig;
   logic signed [EXP_W-1:0] exp_r;
   logic [EXP_FIELD_W-1:0]  exp_field;

   always_comb begin
      result    = '0;
      flags     = '0;
      exp_field = '0;

      guard    = mant[GRD];
      st       = sticky | (|mant[GRD-1:0]);
      round_up = guard & (st | mant[LSB]);
      sig      = {1'b0, mant[HI:LSB]} + (FRAC_W+2)'(round_up);
      exp_r    = exp;

      // A carry out of the significand means it rounded up to 2.0.
      if (sig[FRAC_W+1]) begin
         sig   = sig >> 1;
         exp_r = exp + EXP_W'(1);
      end

      flags.inexact = guard | st;

      if (exp_r >= EXP_OVF) begin
         result         = pack_inf(sign);
         exp_field      = '1;
         flags.overflow = 1'b1;
         flags.inexact  = 1'b1;
      end else begin
         // Without the integer bit the value stays in the subnormal range.
         if (sig[FRAC_W]) begin
            exp_field = exp_r[EXP_FIELD_W-1:0];
         end
         result = {sign, exp_field, sig[FRAC_W-1:0]};
      end

      flags.underflow = (exp_field == '0) & flags.inexact;
   end

endmodule

// File: rtl/fp_mult_norm_round.sv
// Normalize/denormalize/round stage of the single-precision multiplier:
// one-bit-per-cycle shifter FSM feeding a combinational round-and-pack unit.
module fp_mult_norm_round
   import fp_mult_pkg::*;
#(
   parameter int EXP_W      = 10,
   parameter int MANT_W     = 48,
   parameter int MAX_DENORM = 26
) (
   input  logic              clk,
   input  logic              reset,
   fp_mult_norm_round_if.slave bus
);

   localparam int HI = MANT_W - 2;
   localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);
   localparam logic [4:0]              CNT_CAP = 5'(MAX_DENORM);

   state_t                  state_q, state_d;
   logic                    sign_q, sign_d;
   logic signed [EXP_W-1:0] exp_q, exp_d;
   logic [MANT_W-1:0]       mant_q, mant_d;
   logic                    sticky_q, sticky_d;
   logic [4:0]              cnt_q, cnt_d;
   logic [31:0]             result_q, result_d;
   flags_t                  flags_q, flags_d;

   logic [31:0]             rp_result;
   flags_t                  rp_flags;
   logic                    in_ready;
   logic                    out_valid;

   fp_round_pack #(
      .EXP_W  (EXP_W),
      .MANT_W (MANT_W)
   ) u_round_pack (
      .sign   (sign_q),
      .exp    (exp_q),
      .mant   (mant_q[MANT_W-2:0]),
      .sticky (sticky_q),
      .result (rp_result),
      .flags  (rp_flags)
   );

   // NOTE: sequential state is written with <= so every register samples
   // the pre-edge values and the update order inside the block is irrelevant.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sign_q   <= 1'b0;
         exp_q    <= '0;
         mant_q   <= '0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         mant_q   <= mant_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      mant_d    = mant_q;
      sticky_d  = sticky_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      flags_d   = flags_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               sign_d   = bus.in_sign;
               exp_d    = bus.in_exp;
               mant_d   = bus.in_mant;
               sticky_d = 1'b0;
               cnt_d    = '0;
               result_d = '0;
               flags_d  = '0;
               if (bus.in_nan) begin
                  result_d          = QNAN;
                  flags_d.exception = 1'b1;
                  state_d           = DONE;
               end else if (bus.in_inf) begin
                  result_d          = pack_inf(bus.in_sign);
                  flags_d.exception = 1'b1;
                  state_d           = DONE;
               end else if (bus.in_zero || (bus.in_mant == '0)) begin
                  state_d = DONE;
               end else begin
                  state_d = NORM;
               end
            end
         end

         NORM: begin
            if (mant_q[HI+1]) begin
               mant_d   = mant_q >> 1;
               exp_d    = exp_q + EXP_ONE;
               sticky_d = sticky_q | mant_q[0];
            end else if (!mant_q[HI] && (exp_q > EXP_ONE)) begin
               mant_d = mant_q << 1;
               exp_d  = exp_q - EXP_ONE;
            end else if (exp_q < EXP_ONE) begin
               state_d = DENORM;
            end else begin
               state_d = ROUND;
            end
         end

         DENORM: begin
            if ((exp_q < EXP_ONE) && (cnt_q < CNT_CAP)) begin
               mant_d   = mant_q >> 1;
               exp_d    = exp_q + EXP_ONE;
               sticky_d = sticky_q | mant_q[0];
               cnt_d    = cnt_q + 5'd1;
            end else if (exp_q < EXP_ONE) begin
               // Too far below the subnormal range: everything becomes sticky.
               sticky_d = sticky_q | (|mant_q);
               mant_d   = '0;
               exp_d    = EXP_ONE;
               state_d  = ROUND;
            end else begin
               state_d = ROUND;
            end
         end

         ROUND: begin
            result_d = rp_result;
            flags_d  = rp_flags;
            state_d  = DONE;
         end

         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.result    = result_q;
   assign bus.exception = flags_q.exception;
   assign bus.overflow  = flags_q.overflow;
   assign bus.underflow = flags_q.underflow;
   assign bus.inexact   = flags_q.inexact;

endmodule

// File: tb/tb_fp_mult_norm_round.sv
// Directed and randomized checks of fp_mult_norm_round against an exact
// arithmetic model of IEEE single rounding (nearest-even, gradual underflow).
module tb_fp_mult_norm_round;
   import fp_mult_pkg::*;

   localparam int EXP_W  = 10;
   localparam int MANT_W = 48;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   fp_mult_norm_round_if #(.EXP_W(EXP_W), .MANT_W(MANT_W)) bus ();

   fp_mult_norm_round #(
      .EXP_W      (EXP_W),
      .MANT_W     (MANT_W),
      .MAX_DENORM (26)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Value = m/2^46 * 2^(e-BIAS); returns {exception,overflow,underflow,inexact,result}.
   function automatic logic [35:0] ref_model(input logic s, input int e, input logic [47:0] m,
                                             input logic z, input logic inf, input logic nan);
      int         p;
      int         be;
      int         sh;
      longint     mv;
      longint     q;
      longint     r;
      longint     half;
      longint     enc;
      logic       inx;
      logic [63:0] ev;
      if (nan) return {4'b1000, QNAN};
      if (inf) return {4'b1000, s, 8'hFF, 23'h0};
      if (z || (m == '0)) return '0;
      p = 47;
      while (!m[p]) p--;
      // Biased exponent of the value once its leading one sits at 2^0.
      be = (e - BIAS) + (p - 46) + BIAS;
      sh = (be >= 1) ? (p - 23) : (p - 23 + (1 - be));
      mv  = longint'(m);
      inx = 1'b0;
      if (sh <= 0) begin
         q = mv << (-sh);
      end else if (sh > 50) begin
         q   = 0;
         inx = 1'b1;
      end else begin
         q    = mv >> sh;
         r    = mv & ((64'sd1 << sh) - 1);
         half = 64'sd1 << (sh - 1);
         inx  = (r != 0);
         if ((r > half) || ((r == half) && q[0])) q++;
      end
      enc = (be >= 1) ? ((longint'(be - 1) <<< 23) + q) : q;
      if (enc >= (longint'(EXP_MAX) <<< 23)) return {4'b0101, s, 8'hFF, 23'h0};
      ev = enc;
      return {1'b0, 1'b0, (ev[30:23] == 8'h00) && inx, inx, s, ev[30:0]};
   endfunction

   task automatic run_op(input string tag, input logic s, input int e, input logic [47:0] m,
                         input logic z, input logic inf, input logic nan, input int hold,
                         output logic [31:0] res, output logic [3:0] flg, output int lat);
      logic [35:0] expv;
      bit          got;
      expv = ref_model(s, e, m, z, inf, nan);
      @(negedge clk);
      check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_sign  = s;
      bus.in_exp   = EXP_W'(e);
      bus.in_mant  = m;
      bus.in_zero  = z;
      bus.in_inf   = inf;
      bus.in_nan   = nan;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = 0;
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
         @(negedge clk);
         if (bus.out_valid) got = 1'b1;
         else lat++;
      end
      check({tag, " out_valid"}, 32'(got), 32'd1);
      res = bus.result;
      flg = {bus.exception, bus.overflow, bus.underflow, bus.inexact};
      check({tag, " result"}, res, expv[31:0]);
      check({tag, " flags"}, 32'(flg), 32'(expv[35:32]));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, " hold result"}, bus.result, res);
         check({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
         check({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      check({tag, " released"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
   endtask

   initial begin
      logic [31:0] res;
      logic [3:0]  flg;
      int          lat;
      logic [63:0] rnd;
      logic [47:0] m;
      int          e;
      int          mode;
      logic        z;
      logic        inf;
      logic        nan;

      bus.in_valid  = 1'b0;
      bus.in_sign   = 1'b0;
      bus.in_exp    = '0;
      bus.in_mant   = '0;
      bus.in_zero   = 1'b0;
      bus.in_inf    = 1'b0;
      bus.in_nan    = 1'b0;
      bus.out_ready = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset in_ready", 32'(bus.in_ready), 32'd1);
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset result", bus.result, 32'd0);
      check("reset flags", 32'({bus.exception, bus.overflow, bus.underflow, bus.inexact}), 32'd0);
      reset = 1'b1;

      run_op("one_x_one", 1'b0, 127, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 0, res, flg, lat);
      check("one_x_one const", res, 32'h3F80_0000);
      check("one_x_one flagc", 32'(flg), 32'd0);
      check("one_x_one latency", 32'(lat), 32'd2);

      run_op("rshift", 1'b0, 128, 48'hFFFF_F000_0000, 1'b0, 1'b0, 1'b0, 0, res, flg, lat);
      check("rshift const", res, 32'h40FF_FFF0);
      check("rshift flagc", 32'(flg), 32'd0);

      run_op("subnormal", 1'b0, -19, 48'h6804_CC00_0000, 1'b0, 1'b0, 1'b0, 0, res, flg, lat);
      check("subnormal const", res, 32'h0000_000D);
      check("subnormal flagc", 32'(flg), 32'b0011);

      run_op("round_carry", 1'b0, 127, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0, 0, res, flg, lat);
      check("round_carry const", res, 32'h4000_0000);
      check("round_carry flagc", 32'(flg), 32'b0001);

      run_op("overflow", 1'b0, 300, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 0, res, flg, lat);
      check("overflow const", res, 32'h7F80_0000);
      check("overflow flagc", 32'(flg), 32'b0101);

      run_op("nan", 1'b1, 5, 48'h1234_5678_9ABC, 1'b0, 1'b0, 1'b1, 0, res, flg, lat);
      check("nan const", res, 32'h7FC0_0000);
      check("nan flagc", 32'(flg), 32'b1000);
      check("nan latency", 32'(lat <= 1), 32'd1);

      run_op("neg_zero", 1'b1, 127, 48'h4000_0000_0000, 1'b1, 1'b0, 1'b0, 0, res, flg, lat);
      check("neg_zero const", res, 32'h0000_0000);

      run_op("neg_inf", 1'b1, 127, 48'h4000_0000_0000, 1'b0, 1'b1, 1'b0, 0, res, flg, lat);
      check("neg_inf const", res, 32'hFF80_0000);

      run_op("min_subnormal", 1'b0, -23, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 0, res, flg, lat);
      check("min_subnormal const", res, 32'h0000_0001);
      run_op("cap_edge", 1'b1, -25, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 0, res, flg, lat);
      run_op("cap_hit", 1'b0, -40, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 0, res, flg, lat);
      check("cap_hit flagc", 32'(flg), 32'b0011);
      run_op("left_shift", 1'b1, 140, 48'h0000_0012_3457, 1'b0, 1'b0, 1'b0, 0, res, flg, lat);

      run_op("hold", 1'b0, 130, 48'h5A5A_A5A5_1234, 1'b0, 1'b0, 1'b0, 5, res, flg, lat);

      // Abort a long left-normalization with reset part way through.
      @(negedge clk);
      bus.in_sign  = 1'b0;
      bus.in_exp   = EXP_W'(127);
      bus.in_mant  = 48'h0000_0000_0001;
      bus.in_zero  = 1'b0;
      bus.in_inf   = 1'b0;
      bus.in_nan   = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("midop busy", 32'(bus.in_ready), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("midop reset out_valid", 32'(bus.out_valid), 32'd0);
      check("midop reset in_ready", 32'(bus.in_ready), 32'd1);
      check("midop reset result", bus.result, 32'd0);

      for (int i = 0; i < 60; i++) begin
         rnd  = {$urandom, $urandom};
         m    = rnd[47:0] >> $urandom_range(0, 40);
         mode = int'($urandom_range(0, 9));
         z    = 1'b0;
         inf  = 1'b0;
         nan  = 1'b0;
         if (mode <= 5)      e = int'($urandom_range(0, 140)) + 60;
         else if (mode <= 7) e = int'($urandom_range(0, 60)) - 40;
         else if (mode == 8) e = int'($urandom_range(0, 70)) + 230;
         else begin
            e   = int'($urandom_range(0, 255));
            z   = 1'($urandom_range(0, 1));
            inf = 1'($urandom_range(0, 1));
            nan = 1'($urandom_range(0, 1));
         end
         run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), e, m, z, inf, nan,
                int'($urandom_range(0, 2)), res, flg, lat);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
